sdfm_filt_fifo: RTL

- Per-channel result FIFO sitting directly downstream of a sigma-delta channel's data filter.
- Captures each 32-bit filter output on its update strobe and buffers it for the register map to read.
- Raises a level interrupt when fill reaches a programmable threshold, and a sticky overflow flag when the host falls behind.
- One instance per channel; the register map drives the pop and clear controls and reads status.

---
 rtl/sdfm_filt_fifo.sv | 85 ++++++++
 1 files changed

// File: rtl/sdfm_filt_fifo.sv
// Per-channel result FIFO behind a sigma-delta data filter. Captures filter words on
// their update strobe, presents the head word registered (show-ahead), flags level/overflow.
module sdfm_filt_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 5
) (
   input  logic              SYSCLK,
   input  logic              SYSRST,
   input  logic              reg_fifoen,
   input  logic [CNT_W-1:0]  reg_fifolvl,
   input  logic              reg_fifoclr,
   input  logic              reg_ovfclr,
   input  logic [DATA_W-1:0] filt_data_in,
   input  logic              filt_data_update,
   input  logic              rd_pop,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  fifo_cnt,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              fifo_ovf,
   output logic              irq_lvl,
   output logic              irq_ovf
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [DATA_W-1:0] head_nxt;
   logic              flush, push, pop_ok, do_push, ovf_set;

   assign flush      = SYSRST | reg_fifoclr | ~reg_fifoen;
   assign push       = filt_data_update & reg_fifoen;
   assign pop_ok     = rd_pop & ~fifo_empty;
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CNT_W'(DEPTH));
   // A push while full only lands if a pop frees the head slot in the same cycle.
   assign do_push    = push & (~fifo_full | pop_ok);
   assign ovf_set    = push & fifo_full & ~pop_ok;
   assign irq_ovf    = fifo_ovf;

   always_comb begin
      rd_ptr_nxt = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
      cnt_nxt    = fifo_cnt + CNT_W'(do_push) - CNT_W'(pop_ok);
      // The new head may be the word being written this cycle (empty, or one left and popped).
      if (do_push && (wr_ptr == rd_ptr_nxt))
         head_nxt = filt_data_in;
      else
         head_nxt = mem[rd_ptr_nxt];
   end

   always_ff @(posedge SYSCLK) begin
      if (do_push && !flush)
         mem[wr_ptr] <= filt_data_in;
   end

   always_ff @(posedge SYSCLK) begin
      if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         rd_data  <= '0;
         irq_lvl  <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr   <= rd_ptr_nxt;
         fifo_cnt <= cnt_nxt;
         // Popping the last entry leaves the last popped word on rd_data.
         if (cnt_nxt != '0)
            rd_data <= head_nxt;
         irq_lvl  <= (reg_fifolvl != '0) && (cnt_nxt >= reg_fifolvl);
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (SYSRST || reg_fifoclr)
         fifo_ovf <= 1'b0;
      else if (ovf_set)
         fifo_ovf <= 1'b1;
      else if (reg_ovfclr)
         fifo_ovf <= 1'b0;
   end
endmodule
